// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and widths for the register-file write-port arbiter.
package wb_port_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int REG_COUNT  = 32;

    typedef struct packed {
        logic                  we;
        logic [REG_ADDR_W-1:0] rw;
        logic [DATA_W-1:0]     wdata;
    } wb_req_t;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_PIPE,
        SRC_QUEUE,
        SRC_MD
    } wb_src_e;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bundles the pipeline request, multiply/divide stream and register-file port.
interface wb_port_arbiter_if;
    import wb_port_arbiter_pkg::*;

    logic                  pipe_we;
    logic [REG_ADDR_W-1:0] pipe_rw;
    logic [DATA_W-1:0]     pipe_wdata;
    logic                  md_valid;
    logic [REG_ADDR_W-1:0] md_rw;
    logic [DATA_W-1:0]     md_wdata;
    logic                  md_ready;
    logic                  RegWrite;
    logic [REG_ADDR_W-1:0] rw;
    logic [DATA_W-1:0]     wdata;
    logic [REG_COUNT-1:0]  pending_mask;

    modport master (
        output pipe_we, pipe_rw, pipe_wdata, md_valid, md_rw, md_wdata,
        input  md_ready, RegWrite, rw, wdata, pending_mask
    );

    modport slave (
        input  pipe_we, pipe_rw, pipe_wdata, md_valid, md_rw, md_wdata,
        output md_ready, RegWrite, rw, wdata, pending_mask
    );

endinterface

// File: rtl/wb_port_arbiter_defer_queue.sv
// FIFO of deferred multiply/divide writes with per-entry live bit and kill-by-address.
// pending_mask is only computed when WBARB_PENDING_MASK_EN is defined.
module wb_defer_queue
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_push,
    input  logic [REG_ADDR_W-1:0] i_push_rw,
    input  logic [DATA_W-1:0]     i_push_wdata,
    input  logic                  i_pop,
    input  logic                  i_kill_en,
    input  logic [REG_ADDR_W-1:0] i_kill_rw,
    output logic                  o_full,
    output logic                  o_empty,
    output wb_req_t               o_head,
    output logic [REG_COUNT-1:0]  o_pending_mask
);

    localparam int PTR_W = $clog2(DEPTH);

    logic                  r_live  [DEPTH];
    logic [REG_ADDR_W-1:0] r_rw    [DEPTH];
    logic [DATA_W-1:0]     r_wdata [DEPTH];
    logic [PTR_W-1:0]      r_wptr;
    logic [PTR_W-1:0]      r_rptr;
    logic [PTR_W:0]        r_count;

    // Push only lands in a free slot, so it never collides with a kill or pop index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_live[i]  <= 1'b0;
                r_rw[i]    <= '0;
                r_wdata[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i_kill_en && r_live[i] && (r_rw[i] == i_kill_rw))
                    r_live[i] <= 1'b0;
            end
            if (i_pop) begin
                r_live[r_rptr] <= 1'b0;
                r_rptr         <= r_rptr + 1'b1;
            end
            if (i_push) begin
                r_live[r_wptr]  <= 1'b1;
                r_rw[r_wptr]    <= i_push_rw;
                r_wdata[r_wptr] <= i_push_wdata;
                r_wptr          <= r_wptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = '{we: r_live[r_rptr], rw: r_rw[r_rptr], wdata: r_wdata[r_rptr]};

`ifdef WBARB_PENDING_MASK_EN
    logic [REG_COUNT-1:0] w_mask;
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_live[i])
                w_mask[r_rw[i]] = 1'b1;
        end
    end
    assign o_pending_mask = w_mask;
`else
    assign o_pending_mask = '0;
`endif

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writes win, md results defer or cut through.
// Optional WBARB_PENDING_MASK_EN enables the pending_mask output.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    wb_port_arbiter_if.slave bus
);

    logic    w_pe;
    logic    w_me;
    logic    w_full;
    logic    w_empty;
    logic    w_push;
    logic    w_pop;
    wb_req_t w_head;
    wb_src_e w_src;
    wb_req_t r_out;

    assign bus.md_ready = !w_full;
    assign w_pe = bus.pipe_we && (bus.pipe_rw != '0);
    assign w_me = bus.md_valid && !w_full && (bus.md_rw != '0);

    // A result colliding with a pipeline write to the same register is older; drop it.
    always_comb begin
        w_src  = SRC_NONE;
        w_push = 1'b0;
        w_pop  = 1'b0;
        if (w_pe) begin
            w_src  = SRC_PIPE;
            w_push = w_me && (bus.md_rw != bus.pipe_rw);
        end else if (!w_empty) begin
            w_src  = SRC_QUEUE;
            w_pop  = 1'b1;
            w_push = w_me;
        end else if (w_me) begin
            w_src  = SRC_MD;
        end
    end

    wb_defer_queue #(.DEPTH(DEPTH)) u_queue (
        .clk            (clk),
        .reset          (reset),
        .i_push         (w_push),
        .i_push_rw      (bus.md_rw),
        .i_push_wdata   (bus.md_wdata),
        .i_pop          (w_pop),
        .i_kill_en      (w_pe),
        .i_kill_rw      (bus.pipe_rw),
        .o_full         (w_full),
        .o_empty        (w_empty),
        .o_head         (w_head),
        .o_pending_mask (bus.pending_mask)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out <= '0;
        end else begin
            case (w_src)
                SRC_PIPE:  r_out <= '{we: 1'b1, rw: bus.pipe_rw, wdata: bus.pipe_wdata};
                SRC_QUEUE: begin
                    if (w_head.we) r_out    <= w_head;
                    else           r_out.we <= 1'b0;
                end
                SRC_MD:    r_out <= '{we: 1'b1, rw: bus.md_rw, wdata: bus.md_wdata};
                default:   r_out.we <= 1'b0;
            endcase
        end
    end

    assign bus.RegWrite = r_out.we;
    assign bus.rw       = r_out.rw;
    assign bus.wdata    = r_out.wdata;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios plus a randomized run
// against a queue-based model of the arbitration rules.
module tb_wb_port_arbiter;
    import wb_port_arbiter_pkg::*;

    localparam int DEPTH = 2;
`ifdef WBARB_PENDING_MASK_EN
    localparam bit MASK_EN = 1'b1;
`else
    localparam bit MASK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    wb_port_arbiter_if bus();
    wb_port_arbiter #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        bit          live;
        logic [4:0]  rw;
        logic [31:0] d;
    } ent_t;

    ent_t        mq[$];
    logic        e_we;
    logic [4:0]  e_rw;
    logic [31:0] e_wd;
    logic        o_ready;
    bit          m_ready;

    function automatic logic [31:0] model_mask();
        logic [31:0] m = '0;
        if (MASK_EN) foreach (mq[i]) if (mq[i].live) m[mq[i].rw] = 1'b1;
        return m;
    endfunction

    task automatic model_reset();
        mq.delete();
        e_we = 1'b0; e_rw = '0; e_wd = '0;
    endtask

    task automatic model_step(input logic pwe, input logic [4:0] prw, input logic [31:0] pwd,
                              input logic mv, input logic [4:0] mrw, input logic [31:0] mwd,
                              input bit rdy);
        bit   pe, me;
        ent_t h;
        pe = pwe && (prw != 0);
        me = mv && rdy && (mrw != 0);
        if (pe) begin
            foreach (mq[i]) if (mq[i].rw == prw) mq[i].live = 1'b0;
            e_we = 1'b1; e_rw = prw; e_wd = pwd;
            if (me && mrw != prw) mq.push_back('{live: 1'b1, rw: mrw, d: mwd});
        end else if (mq.size() > 0) begin
            h = mq.pop_front();
            if (h.live) begin e_we = 1'b1; e_rw = h.rw; e_wd = h.d; end
            else e_we = 1'b0;
            if (me) mq.push_back('{live: 1'b1, rw: mrw, d: mwd});
        end else if (me) begin
            e_we = 1'b1; e_rw = mrw; e_wd = mwd;
        end else begin
            e_we = 1'b0;
        end
    endtask

    task automatic run_cycle(input logic pwe, input logic [4:0] prw, input logic [31:0] pwd,
                             input logic mv, input logic [4:0] mrw, input logic [31:0] mwd);
        bus.pipe_we = pwe; bus.pipe_rw = prw; bus.pipe_wdata = pwd;
        bus.md_valid = mv; bus.md_rw = mrw; bus.md_wdata = mwd;
        @(negedge clk);
        o_ready = bus.md_ready;
        m_ready = (mq.size() < DEPTH);
        model_step(pwe, prw, pwd, mv, mrw, mwd, m_ready);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) run_cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.pipe_we = 1'b0; bus.pipe_rw = '0; bus.pipe_wdata = '0;
        bus.md_valid = 1'b1; bus.md_rw = 5'd5; bus.md_wdata = 32'h1234;
        model_reset();
        #2;
        n_checks++; if (bus.RegWrite !== 1'b0) $display("FAIL reset_we: got %b want 0", bus.RegWrite); else n_pass++;
        n_checks++; if (bus.rw !== 5'd0) $display("FAIL reset_rw: got %0d want 0", bus.rw); else n_pass++;
        n_checks++; if (bus.wdata !== 32'd0) $display("FAIL reset_wdata: got %h want 0", bus.wdata); else n_pass++;
        n_checks++; if (bus.md_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus.md_ready); else n_pass++;
        n_checks++; if (bus.pending_mask !== 32'd0) $display("FAIL reset_mask: got %h want 0", bus.pending_mask); else n_pass++;
        @(posedge clk); @(negedge clk);
        n_checks++; if (bus.RegWrite !== 1'b0) $display("FAIL reset_hold_we: got %b want 0", bus.RegWrite); else n_pass++;
        bus.md_valid = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_cut_through();
        run_cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h1234);
        n_checks++; if (o_ready !== 1'b1) $display("FAIL ct_ready: got %b want 1", o_ready); else n_pass++;
        n_checks++; if (bus.RegWrite !== 1'b1) $display("FAIL ct_we: got %b want 1", bus.RegWrite); else n_pass++;
        n_checks++; if (bus.rw !== 5'd5) $display("FAIL ct_rw: got %0d want 5", bus.rw); else n_pass++;
        n_checks++; if (bus.wdata !== 32'h1234) $display("FAIL ct_wdata: got %h want 1234", bus.wdata); else n_pass++;
        n_checks++; if (bus.pending_mask !== 32'd0) $display("FAIL ct_mask: got %h want 0", bus.pending_mask); else n_pass++;
        idle_cycles(1);
        n_checks++; if (bus.RegWrite !== 1'b0) $display("FAIL ct_empty_we: got %b want 0", bus.RegWrite); else n_pass++;
        n_checks++; if (bus.rw !== 5'd5) $display("FAIL ct_hold_rw: got %0d want 5", bus.rw); else n_pass++;
    endtask

    task automatic test_collision();
        logic [31:0] want_mask;
        want_mask = MASK_EN ? 32'h0000_0080 : 32'h0;
        run_cycle(1'b1, 5'd3, 32'hA, 1'b1, 5'd7, 32'hB);
        n_checks++; if ({bus.RegWrite, bus.rw, bus.wdata} !== {1'b1, 5'd3, 32'hA})
            $display("FAIL col_c1: got we=%b rw=%0d d=%h want 1/3/a", bus.RegWrite, bus.rw, bus.wdata); else n_pass++;
        n_checks++; if (bus.pending_mask !== want_mask)
            $display("FAIL col_mask1: got %h want %h", bus.pending_mask, want_mask); else n_pass++;
        idle_cycles(1);
        n_checks++; if ({bus.RegWrite, bus.rw, bus.wdata} !== {1'b1, 5'd7, 32'hB})
            $display("FAIL col_c2: got we=%b rw=%0d d=%h want 1/7/b", bus.RegWrite, bus.rw, bus.wdata); else n_pass++;
        n_checks++; if (bus.pending_mask !== 32'd0)
            $display("FAIL col_mask2: got %h want 0", bus.pending_mask); else n_pass++;
        idle_cycles(1);
    endtask

    task automatic test_waw_kill();
        bit stale_seen = 1'b0;
        run_cycle(1'b1, 5'd3, 32'hA, 1'b1, 5'd7, 32'hB);
        run_cycle(1'b1, 5'd7, 32'hC, 1'b0, 5'd0, 32'd0);
        n_checks++; if ({bus.RegWrite, bus.rw, bus.wdata} !== {1'b1, 5'd7, 32'hC})
            $display("FAIL waw_new: got we=%b rw=%0d d=%h want 1/7/c", bus.RegWrite, bus.rw, bus.wdata); else n_pass++;
        n_checks++; if (bus.pending_mask !== 32'd0)
            $display("FAIL waw_mask: got %h want 0", bus.pending_mask); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            idle_cycles(1);
            if (bus.RegWrite && bus.rw == 5'd7 && bus.wdata == 32'hB) stale_seen = 1'b1;
            n_checks++; if (bus.RegWrite !== 1'b0)
                $display("FAIL waw_dead_pop%0d: got we=%b want 0", i, bus.RegWrite); else n_pass++;
        end
        n_checks++; if (stale_seen !== 1'b0) $display("FAIL waw_stale: got %b want 0", stale_seen); else n_pass++;
        n_checks++; if (bus.md_ready !== 1'b1) $display("FAIL waw_ready: got %b want 1", bus.md_ready); else n_pass++;
    endtask

    task automatic test_full_queue();
        logic        pwe_v [7] = '{1, 1, 1, 0, 0, 0, 0};
        logic        mv_v  [7] = '{1, 1, 1, 1, 1, 0, 0};
        logic [4:0]  mrw_v [7] = '{10, 11, 12, 12, 12, 0, 0};
        logic        rdy_v [7] = '{1, 1, 0, 0, 1, 1, 1};
        logic        we_v  [7] = '{1, 1, 1, 1, 1, 1, 0};
        logic [4:0]  rw_v  [7] = '{1, 2, 3, 10, 11, 12, 12};
        logic [31:0] d_v   [7] = '{32'h11, 32'h22, 32'h33, 32'h100, 32'h101, 32'h102, 32'h102};
        logic [4:0]  prw;
        for (int c = 0; c < 7; c++) begin
            prw = 5'(c + 1);
            run_cycle(pwe_v[c], prw, {24'd0, prw, prw[3:0]} & 32'hFF, mv_v[c], mrw_v[c],
                      32'h100 + 32'(mrw_v[c]) - 32'd10);
            n_checks++; if (o_ready !== rdy_v[c])
                $display("FAIL full_ready%0d: got %b want %b", c, o_ready, rdy_v[c]); else n_pass++;
            n_checks++; if (bus.RegWrite !== we_v[c])
                $display("FAIL full_we%0d: got %b want %b", c, bus.RegWrite, we_v[c]); else n_pass++;
            n_checks++; if ({bus.rw, bus.wdata} !== {rw_v[c], d_v[c]})
                $display("FAIL full_data%0d: got rw=%0d d=%h want rw=%0d d=%h", c, bus.rw, bus.wdata, rw_v[c], d_v[c]);
            else n_pass++;
        end
    endtask

    task automatic test_r0();
        run_cycle(1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h66);
        n_checks++; if (o_ready !== 1'b1) $display("FAIL r0_ready1: got %b want 1", o_ready); else n_pass++;
        n_checks++; if (bus.RegWrite !== 1'b0) $display("FAIL r0_we1: got %b want 0", bus.RegWrite); else n_pass++;
        run_cycle(1'b1, 5'd5, 32'h77, 1'b1, 5'd0, 32'h88);
        n_checks++; if ({bus.RegWrite, bus.rw, bus.wdata} !== {1'b1, 5'd5, 32'h77})
            $display("FAIL r0_pipe: got we=%b rw=%0d d=%h want 1/5/77", bus.RegWrite, bus.rw, bus.wdata); else n_pass++;
        n_checks++; if (bus.pending_mask !== 32'd0) $display("FAIL r0_mask: got %h want 0", bus.pending_mask); else n_pass++;
        run_cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h99);
        n_checks++; if (bus.RegWrite !== 1'b0) $display("FAIL r0_we3: got %b want 0", bus.RegWrite); else n_pass++;
        n_checks++; if (o_ready !== 1'b1) $display("FAIL r0_ready3: got %b want 1", o_ready); else n_pass++;
    endtask

    task automatic test_reset_mid();
        run_cycle(1'b1, 5'd3, 32'hA, 1'b1, 5'd7, 32'hB);
        run_cycle(1'b1, 5'd4, 32'hD, 1'b1, 5'd9, 32'hE);
        bus.pipe_we = 1'b0; bus.md_valid = 1'b0;
        reset = 1'b1;
        #1;
        n_checks++; if ({bus.RegWrite, bus.rw, bus.wdata} !== 38'd0)
            $display("FAIL mid_reset_out: got we=%b rw=%0d d=%h want 0", bus.RegWrite, bus.rw, bus.wdata); else n_pass++;
        n_checks++; if (bus.md_ready !== 1'b1) $display("FAIL mid_reset_ready: got %b want 1", bus.md_ready); else n_pass++;
        n_checks++; if (bus.pending_mask !== 32'd0) $display("FAIL mid_reset_mask: got %h want 0", bus.pending_mask); else n_pass++;
        model_reset();
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        idle_cycles(2);
        n_checks++; if (bus.RegWrite !== 1'b0) $display("FAIL mid_reset_discard: got %b want 0", bus.RegWrite); else n_pass++;
    endtask

    task automatic test_random();
        logic        pwe, mv;
        logic [4:0]  prw, mrw;
        logic [31:0] pwd, mwd;
        for (int c = 0; c < 600; c++) begin
            pwe = 1'($urandom_range(0, 1));
            prw = 5'($urandom_range(0, 7));
            mv  = ($urandom_range(0, 9) < 6);
            mrw = 5'($urandom_range(0, 7));
            pwd = $urandom; mwd = $urandom;
            if (c >= 550) begin pwe = 1'b0; mv = 1'b0; end
            run_cycle(pwe, prw, pwd, mv, mrw, mwd);
            n_checks++; if (o_ready !== m_ready)
                $display("FAIL rnd_ready@%0d: got %b want %b", c, o_ready, m_ready); else n_pass++;
            n_checks++; if ({bus.RegWrite, bus.rw, bus.wdata} !== {e_we, e_rw, e_wd})
                $display("FAIL rnd_out@%0d: got we=%b rw=%0d d=%h want we=%b rw=%0d d=%h",
                         c, bus.RegWrite, bus.rw, bus.wdata, e_we, e_rw, e_wd); else n_pass++;
            n_checks++; if (bus.pending_mask !== model_mask())
                $display("FAIL rnd_mask@%0d: got %h want %h", c, bus.pending_mask, model_mask()); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_cut_through();
        test_collision();
        test_waw_kill();
        test_full_queue();
        test_r0();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
